driver_teclado_lectura: RTL and testbench
=========================================

# driver_teclado_lectura

Column reader and key decoder for the 4x4 passive membrane keypad. It drives the active-low row lines from the row index produced by the scan counter, and samples the active-low column lines. It debounces press and release, then emits a 4-bit key code with a one-cycle valid strobe. While a key is held it deasserts `hab_out`, which feeds the scan counter's enable and freezes the sweep on the pressed row.

## Interface
- `DEB_CYCLES`, default 500000: debounce length in `clk_50` cycles (10 ms); legal range 2..2^20-1.
- `REPEAT_CYCLES`, default 25000000: auto-repeat period in `clk_50` cycles (0.5 s); used only with `TECLADO_REPEAT_EN`.
- `clk_50` input 1: system clock; all logic on its rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `index_in` input 2: row index from the scan counter; may be asynchronous to `clk_50`.
- `col_in` input 4: keypad columns, active-low, asynchronous.
- `fila_out` output 4: row drive, active-low one-hot, registered.
- `hab_out` output 1: scan enable to the scan counter; 1 = sweep, 0 = freeze.
- `tecla_out` output 4: key code = row*4 + column, registered, held until the next valid key.
- `tecla_valida` output 1: one-cycle strobe, asserted when `tecla_out` is updated.
- `tecla_presionada` output 1: level, high from debounced press to debounced release.

## Operation
- `index_in` and `col_in` each pass through a two-flop synchronizer, giving `index_s` and `col_s`.
- `fila_out` is registered as `~(4'b0001 << index_s)`.
- Column priority: the lowest-numbered low bit of `col_s` wins. `col_s` = 4'b1111 means no key.
- FSM, four states, with a 20-bit debounce counter `cnt`:
  - **IDLE**: `hab_out`=1. If any `col_s` bit is low, capture `fila_c`=`index_s` and `col_c`=the winning column, clear `cnt`, go to DEB_PRESS.
  - **DEB_PRESS**: `hab_out`=0.
    - If `col_s[col_c]` is high, or `index_s` != `fila_c`, go to IDLE with no strobe.
    - Otherwise increment `cnt`.
    - When `cnt`==DEB_CYCLES-1: go to PRESSED, load `tecla_out`={`fila_c`,`col_c`}, pulse `tecla_valida`, set `tecla_presionada`=1.
  - **PRESSED**: `hab_out`=0. If `col_s[col_c]` is high, clear `cnt` and go to DEB_RELEASE.
  - **DEB_RELEASE**: `hab_out`=0.
    - If `col_s[col_c]` goes low, return to PRESSED with no new strobe.
    - When `cnt`==DEB_CYCLES-1: go to IDLE, `tecla_presionada`=0, `hab_out`=1.
- Other columns going low while in PRESSED or DEB_RELEASE are ignored (no rollover).
- The counter never wraps: it is cleared on every state entry and compared for equality.
- Reset values: IDLE, `cnt`=0, `fila_out`=4'b1111, `hab_out`=1, `tecla_out`=4'h0, `tecla_valida`=0, `tecla_presionada`=0, synchronizers=all-ones / 2'b00.
- Reset has priority over every state, including mid-debounce and PRESSED. Outputs take their reset values at the first rising edge with `rst_n`=0.

## Timing
- Input change to synchronized value: 2 cycles.
- `index_in` change to `fila_out`: 3 cycles.
- Column low to DEB_PRESS entry (`hab_out`=0): 3 cycles.
- DEB_PRESS entry to `tecla_valida`: DEB_CYCLES cycles. Total press latency is DEB_CYCLES+3.
- `tecla_valida` is high for exactly 1 cycle. `tecla_out` and `tecla_presionada` change in that same cycle.
- Release: column high to `tecla_presionada`=0 takes DEB_CYCLES+3 cycles.
- `hab_out` returns to 1 in the same cycle as `tecla_presionada` falls.
- If the scan counter advances before `hab_out` reaches it, the `index_s` mismatch aborts DEB_PRESS and the key is caught on the next sweep.

## Configuration
- Macro `TECLADO_REPEAT_EN`.
- **Defined**: a 25-bit counter runs in PRESSED and is cleared on PRESSED entry.
  - Each time it reaches REPEAT_CYCLES-1, it re-pulses `tecla_valida` for 1 cycle with `tecla_out` unchanged, then restarts.
  - A return from DEB_RELEASE to PRESSED does not clear it.
- **Undefined**: no repeat logic is present; exactly one strobe per debounced press.

## Test plan
(DEB_CYCLES=4, REPEAT_CYCLES=10 in simulation)
- **Reset**: hold `rst_n`=0 for 3 cycles with `col_in`=4'b0000 → `fila_out`=4'b1111, `hab_out`=1, `tecla_out`=0, `tecla_valida`=0, `tecla_presionada`=0.
- **Clean press**: `index_in`=2, `col_in`=4'b1101 held → `hab_out`=0 at cycle 3; `tecla_valida` pulses once at cycle 7 with `tecla_out`=4'h9 and `tecla_presionada`=1.
- **Bounce**: `col_in`=4'b1110 for 2 cycles after DEB_PRESS entry, then 4'b1111 → no strobe; `hab_out` back to 1.
- **Priority**: `index_in`=0, `col_in`=4'b1001 → `tecla_out`=4'h1.
- **Release**:
  - Glitch low for 1 cycle during DEB_RELEASE → `tecla_presionada` stays 1 and no second strobe.
  - Clean release → `tecla_presionada`=0 and `hab_out`=1 DEB_CYCLES+3 cycles after the columns go high.
  - `rst_n`=0 while PRESSED → all outputs at reset values on the next edge.
- **Repeat**: with `TECLADO_REPEAT_EN`, hold the key → strobes at cycle 7, then every 10 cycles, with `tecla_out` constant. Without the macro → a single strobe.

Source files
------------

// File: rtl/driver_teclado_lectura.sv
// -----------------------------------------------------------------------------
// driver_teclado_lectura
//
// Column reader and key decoder for a 4x4 passive membrane keypad.
// Drives the active-low row lines from the scan counter's row index, samples
// the active-low column lines, debounces press and release, and reports a
// 4-bit key code (row*4 + column) with a one-cycle valid strobe. While a key
// is held, hab_out is dropped so the scan counter freezes on the pressed row.
//
// Optional feature (macro TECLADO_REPEAT_EN):
//   defined   - auto-repeat: tecla_valida re-pulses every REPEAT_CYCLES
//               cycles while the key stays in PRESSED.
//   undefined - exactly one strobe per debounced press.
//
// Parameters:
//   DEB_CYCLES     debounce length in clk_50 cycles (2 .. 2^20-1)
//   REPEAT_CYCLES  auto-repeat period in clk_50 cycles (repeat build only)
//
// Ports:
//   clk_50            in   system clock, rising edge
//   rst_n             in   synchronous active-low reset
//   index_in[1:0]     in   row index from scan counter (asynchronous)
//   col_in[3:0]       in   keypad columns, active-low (asynchronous)
//   fila_out[3:0]     out  row drive, active-low one-hot, registered
//   hab_out           out  scan enable: 1 = sweep, 0 = freeze
//   tecla_out[3:0]    out  key code, held until the next valid key
//   tecla_valida      out  one-cycle strobe when tecla_out is (re)issued
//   tecla_presionada  out  high from debounced press to debounced release
// -----------------------------------------------------------------------------
//
// state         | meaning
// --------------+--------------------------------------------------------------
// S_IDLE        | no key; scan sweeping, waiting for any column to go low
// S_DEB_PRESS   | candidate key captured; must stay low on the same row
// S_PRESSED     | key accepted and reported; waiting for its column to rise
// S_DEB_RELEASE | column high; must stay high for the debounce time
// -----------------------------------------------------------------------------

module driver_teclado_lectura #(
  parameter int DEB_CYCLES    = 500000,
  parameter int REPEAT_CYCLES = 25000000
) (
  input  logic       clk_50,
  input  logic       rst_n,
  input  logic [1:0] index_in,
  input  logic [3:0] col_in,
  output logic [3:0] fila_out,
  output logic       hab_out,
  output logic [3:0] tecla_out,
  output logic       tecla_valida,
  output logic       tecla_presionada
);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_DEB_PRESS   = 2'd1,
    S_PRESSED     = 2'd2,
    S_DEB_RELEASE = 2'd3
  } state_t;

  localparam logic [19:0] DEB_LAST = 20'(DEB_CYCLES - 1);

  // Elaboration-time guard on parameter ranges.
  if (DEB_CYCLES < 2 || DEB_CYCLES > 1048575) begin : g_bad_deb
    $error("driver_teclado_lectura: DEB_CYCLES out of range");
  end
  if (REPEAT_CYCLES < 2 || REPEAT_CYCLES > 33554431) begin : g_bad_rep
    $error("driver_teclado_lectura: REPEAT_CYCLES out of range");
  end

  // Synchronizers
  logic [1:0] r_idx_m;
  logic [1:0] r_idx_s;
  logic [3:0] r_col_m;
  logic [3:0] r_col_s;

  // Core state
  state_t     r_state;
  state_t     w_state_next;
  logic [19:0] r_cnt;
  logic [1:0] r_fila_c;
  logic [1:0] r_col_c;

  // Output registers
  logic [3:0] r_fila;
  logic [3:0] r_tecla;
  logic       r_valida;
  logic       r_pres;

  // Combinational decode
  logic       w_any_low;
  logic [1:0] w_col_win;
  logic       w_col_hit;
  logic       w_row_same;
  logic       w_cnt_last;
  logic       w_hab;
  logic       w_capture;
  logic       w_cnt_inc;
  logic       w_press_done;
  logic       w_release_done;
  logic       w_rep_fire;

  // Lowest-numbered low column wins.
  always_comb begin
    w_any_low = ~&r_col_s;
    w_col_win = 2'd0;
    if (!r_col_s[0]) begin
      w_col_win = 2'd0;
    end else if (!r_col_s[1]) begin
      w_col_win = 2'd1;
    end else if (!r_col_s[2]) begin
      w_col_win = 2'd2;
    end else if (!r_col_s[3]) begin
      w_col_win = 2'd3;
    end
  end

  // Only the captured column is tracked after capture, which is what makes
  // other keys on the same row invisible (no rollover).
  assign w_col_hit  = ~r_col_s[r_col_c];
  assign w_row_same = (r_idx_s == r_fila_c);
  assign w_cnt_last = (r_cnt == DEB_LAST);

  // Next-state and control
  always_comb begin
    w_state_next   = r_state;
    w_hab          = 1'b0;
    w_capture      = 1'b0;
    w_cnt_inc      = 1'b0;
    w_press_done   = 1'b0;
    w_release_done = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_hab = 1'b1;
        if (w_any_low) begin
          w_capture    = 1'b1;
          w_state_next = S_DEB_PRESS;
        end
      end

      S_DEB_PRESS: begin
        // A row change means the scan counter moved before the freeze took
        // effect; drop the candidate and catch it on the next sweep.
        if (!w_col_hit || !w_row_same) begin
          w_state_next = S_IDLE;
        end else if (w_cnt_last) begin
          w_press_done = 1'b1;
          w_state_next = S_PRESSED;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end

      S_PRESSED: begin
        if (!w_col_hit) begin
          w_state_next = S_DEB_RELEASE;
        end
      end

      S_DEB_RELEASE: begin
        if (w_col_hit) begin
          w_state_next = S_PRESSED;
        end else if (w_cnt_last) begin
          w_release_done = 1'b1;
          w_state_next   = S_IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Sequential core
  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      r_idx_m  <= 2'b00;
      r_idx_s  <= 2'b00;
      r_col_m  <= 4'b1111;
      r_col_s  <= 4'b1111;
      r_state  <= S_IDLE;
      r_cnt    <= 20'd0;
      r_fila_c <= 2'd0;
      r_col_c  <= 2'd0;
      r_fila   <= 4'b1111;
      r_tecla  <= 4'h0;
      r_valida <= 1'b0;
      r_pres   <= 1'b0;
    end else begin
      r_idx_m <= index_in;
      r_idx_s <= r_idx_m;
      r_col_m <= col_in;
      r_col_s <= r_col_m;

      r_fila  <= ~(4'b0001 << r_idx_s);

      r_state <= w_state_next;

      // Counter is cleared on every state change, so it never wraps.
      if (w_state_next != r_state) begin
        r_cnt <= 20'd0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + 20'd1;
      end

      if (w_capture) begin
        r_fila_c <= r_idx_s;
        r_col_c  <= w_col_win;
      end

      r_valida <= w_press_done | w_rep_fire;

      if (w_press_done) begin
        r_tecla <= {r_fila_c, r_col_c};
      end

      if (w_press_done) begin
        r_pres <= 1'b1;
      end else if (w_release_done) begin
        r_pres <= 1'b0;
      end
    end
  end

`ifdef TECLADO_REPEAT_EN
  localparam logic [24:0] REP_LAST = 25'(REPEAT_CYCLES - 1);

  logic [24:0] r_rep;

  // Cleared only on entry from DEB_PRESS; a bounce back from DEB_RELEASE
  // keeps the running period so the repeat cadence is not disturbed.
  assign w_rep_fire = (r_state == S_PRESSED) && (r_rep == REP_LAST);

  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      r_rep <= 25'd0;
    end else if (w_press_done) begin
      r_rep <= 25'd0;
    end else if (r_state == S_PRESSED) begin
      if (w_rep_fire) begin
        r_rep <= 25'd0;
      end else begin
        r_rep <= r_rep + 25'd1;
      end
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  assign fila_out         = r_fila;
  assign hab_out          = w_hab;
  assign tecla_out        = r_tecla;
  assign tecla_valida     = r_valida;
  assign tecla_presionada = r_pres;

endmodule

// File: tb/tb_driver_teclado_lectura.sv
module tb_driver_teclado_lectura;

  localparam int DEB = 4;
  localparam int REP = 10;

  logic       clk_50 = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] index_in = 2'd0;
  logic [3:0] col_in = 4'hF;
  logic [3:0] fila_out;
  logic       hab_out;
  logic [3:0] tecla_out;
  logic       tecla_valida;
  logic       tecla_presionada;

  driver_teclado_lectura #(
    .DEB_CYCLES   (DEB),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk_50          (clk_50),
    .rst_n           (rst_n),
    .index_in        (index_in),
    .col_in          (col_in),
    .fila_out        (fila_out),
    .hab_out         (hab_out),
    .tecla_out       (tecla_out),
    .tecla_valida    (tecla_valida),
    .tecla_presionada(tecla_presionada)
  );

  always #5 clk_50 = ~clk_50;

  int cyc = 0;
  always @(posedge clk_50) cyc <= cyc + 1;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_q[$];
  int         strobe_cnt = 0;
  int         strobe_cyc = -1;
  logic       prev_valid = 1'b0;
  logic [3:0] mon_exp;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected key.
  always @(negedge clk_50) begin
    if (rst_n) begin
      if (tecla_valida) begin
        strobe_cnt++;
        strobe_cyc = cyc;
        check("valid_one_cycle", {31'd0, prev_valid}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got key %0d expected no strobe", tecla_out);
        end else begin
          mon_exp = exp_q.pop_front();
          check("key_code", {28'd0, tecla_out}, {28'd0, mon_exp});
        end
        check("pressed_with_strobe", {31'd0, tecla_presionada}, 32'd1);
      end
      prev_valid = tecla_valida;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Reference rules: key = row*4 + lowest low column; repeat count from hold.
  function automatic logic [3:0] key_of(int row, logic [3:0] c);
    int col;
    col = 0;
    for (int i = 3; i >= 0; i--) if (!c[i]) col = i;
    return 4'(row * 4 + col);
  endfunction

  // Column held low for h input cycles: press reported 7 cycles in, the key
  // leaves the held state h+3 cycles in.
  function automatic int exp_strobes(int h);
`ifdef TECLADO_REPEAT_EN
    return 1 + (h + 3 - 8) / REP;
`else
    return (h > 0) ? 1 : 0;
`endif
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk_50);
    #1;
  endtask

  task automatic push_key(logic [3:0] k, int n);
    repeat (n) exp_q.push_back(k);
  endtask

  task automatic wait_strobes(int target, int budget, string name);
    int b;
    b = budget;
    while (strobe_cnt < target && b > 0) begin
      tick(1);
      b--;
    end
    if (strobe_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got %0d strobes expected %0d", name, strobe_cnt, target);
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_fila"},  {28'd0, fila_out},  32'hF);
    check({tag, "_hab"},   {31'd0, hab_out},   32'd1);
    check({tag, "_tecla"}, {28'd0, tecla_out}, 32'd0);
    check({tag, "_valid"}, {31'd0, tecla_valida}, 32'd0);
    check({tag, "_pres"},  {31'd0, tecla_presionada}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int s0;
    int row;
    int len;
    logic [3:0] m;

    // Reset with all columns low
    rst_n    = 1'b0;
    col_in   = 4'b0000;
    index_in = 2'd0;
    tick(1);
    check_reset_outputs("reset_first_edge");
    tick(2);
    check_reset_outputs("reset_held");
    col_in = 4'hF;
    rst_n  = 1'b1;
    tick(4);

    // Clean press row 2, column 1 -> key 9
    index_in = 2'd2;
    tick(4);
    check("fila_row2", {28'd0, fila_out}, 32'hB);
    push_key(4'h9, 1);
    s0 = strobe_cnt;
    t0 = cyc;
    col_in = 4'b1101;
    tick(2);
    check("press_hab_cycle2", {31'd0, hab_out}, 32'd1);
    tick(1);
    check("press_hab_cycle3", {31'd0, hab_out}, 32'd0);
    wait_strobes(s0 + 1, 20, "clean_press");
    check("press_latency", strobe_cyc - t0, 32'd7);
    check("press_pres_level", {31'd0, tecla_presionada}, 32'd1);
    check("press_hab_frozen", {31'd0, hab_out}, 32'd0);

    // Release with a one-cycle glitch inside the release debounce
    col_in = 4'hF;
    tick(3);
    col_in = 4'b1101;
    tick(1);
    col_in = 4'hF;
    tick(4);
    check("glitch_pres_held", {31'd0, tecla_presionada}, 32'd1);
    tick(10);
    check("glitch_released_pres", {31'd0, tecla_presionada}, 32'd0);
    check("glitch_released_hab", {31'd0, hab_out}, 32'd1);
    check("glitch_no_restrobe", strobe_cnt, s0 + 1);

    // Bounce: short low never reaches the debounce length
    s0 = strobe_cnt;
    col_in = 4'b1110;
    tick(2);
    col_in = 4'hF;
    tick(1);
    check("bounce_hab_frozen", {31'd0, hab_out}, 32'd0);
    tick(2);
    check("bounce_hab_back", {31'd0, hab_out}, 32'd1);
    tick(8);
    check("bounce_no_strobe", strobe_cnt, s0);

    // Priority: two columns low on row 0 -> lowest wins (key 1)
    index_in = 2'd0;
    tick(4);
    push_key(4'h1, 1);
    s0 = strobe_cnt;
    col_in = 4'b1001;
    wait_strobes(s0 + 1, 20, "priority");
    check("priority_pres", {31'd0, tecla_presionada}, 32'd1);

    // Clean release timing
    tick(2);
    col_in = 4'hF;
    tick(6);
    check("release_pres_cycle6", {31'd0, tecla_presionada}, 32'd1);
    check("release_hab_cycle6", {31'd0, hab_out}, 32'd0);
    tick(1);
    check("release_pres_cycle7", {31'd0, tecla_presionada}, 32'd0);
    check("release_hab_cycle7", {31'd0, hab_out}, 32'd1);
    check("release_tecla_held", {28'd0, tecla_out}, 32'h1);
    tick(4);

    // Long hold: single strobe, or periodic strobes with auto-repeat
    index_in = 2'd1;
    tick(4);
    push_key(4'h7, exp_strobes(30));
    s0 = strobe_cnt;
    col_in = 4'b0111;
    tick(30);
    col_in = 4'hF;
    tick(15);
    check("hold_strobe_count", strobe_cnt, s0 + exp_strobes(30));

    // Reset while PRESSED
    index_in = 2'd3;
    tick(4);
    push_key(key_of(3, 4'b1011), 1);
    s0 = strobe_cnt;
    col_in = 4'b1011;
    wait_strobes(s0 + 1, 20, "pre_reset_press");
    tick(2);
    rst_n = 1'b0;
    tick(1);
    check_reset_outputs("reset_pressed");
    col_in = 4'hF;
    tick(2);
    rst_n = 1'b1;
    tick(4);

    // Randomized presses and bounces
    for (int it = 0; it < 24; it++) begin
      row = $urandom_range(0, 3);
      m   = 4'($urandom_range(0, 14));
      index_in = 2'(row);
      tick(4);
      if ($urandom_range(0, 2) == 0) begin
        len = $urandom_range(1, 3);
      end else begin
        len = $urandom_range(8, 12);
        push_key(key_of(row, m), exp_strobes(len));
      end
      col_in = m;
      tick(len);
      col_in = 4'hF;
      tick(12);
    end

    tick(20);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
